alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 56 +++++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, shared-ALU and response signals of the ALU arbiter
//
// Purpose : bundles the two requester channels, the shared ALU connection and
//           the response channel into one interface.
// Modports: slave  - the arbiter (accepts requests, drives ALU operands and responses)
//           master - the surroundings (requesters, combinational ALU, response consumer)
// Signals : reqN_valid/ready, reqN_a/b (32), reqN_op (4)   requester N
//           alu_a/alu_b (32), alu_op (4)                   operands to the ALU
//           alu_result (32), alu_flags (4)                 {carry, overflow, zero, set}
//           rsp_valid/ready, rsp_id, rsp_result (32), rsp_flags (4), rsp_err
//           busy                                           arbiter not idle

interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [3:0]  req0_op;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  req1_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err;
   logic        busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_op,
      input  alu_result, alu_flags,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_op,
      output alu_result, alu_flags,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy,
      output rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
//
// Purpose : grants one of two requesters in IDLE (round-robin when FAIR=1,
//           requester 0 priority when FAIR=0), drives the latched operation to
//           the ALU for one EXEC cycle, captures the result and holds it in
//           RESP until the consumer takes it. Illegal opcodes skip EXEC and
//           answer with rsp_err=1.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - alu_arbiter_if.slave (requesters, ALU, response, busy)

module alu_arbiter #(
   parameter int FAIR = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   state_t      state_nxt;

   logic        last_grant;
   logic [31:0] lat_a;
   logic [31:0] lat_b;
   logic [3:0]  lat_op;
   logic        rsp_id_q;
   logic [31:0] rsp_result_q;
   logic [3:0]  rsp_flags_q;
   logic        rsp_err_q;

   logic        grant_id;
   logic        accept;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [3:0]  sel_op;
   logic        sel_legal;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
         4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010: op_legal = 1'b1;
         default:                                     op_legal = 1'b0;
      endcase
   endfunction

   // Grant choice: a lone requester always wins; on a tie the fair variant
   // picks whoever was not served last, the priority variant picks 0.
   always_comb begin
      grant_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         grant_id = (FAIR != 0) ? ~last_grant : 1'b0;
      else if (bus.req1_valid)
         grant_id = 1'b1;
   end

   assign sel_a     = grant_id ? bus.req1_a  : bus.req0_a;
   assign sel_b     = grant_id ? bus.req1_b  : bus.req0_b;
   assign sel_op    = grant_id ? bus.req1_op : bus.req0_op;
   assign sel_legal = op_legal(sel_op);
   assign accept    = (state == IDLE) && (bus.req0_valid || bus.req1_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      bus.alu_op     = '0;
      bus.rsp_valid  = 1'b0;
      bus.busy       = 1'b1;
      case (state)
         IDLE: begin
            bus.busy       = 1'b0;
            bus.req0_ready = accept && !grant_id;
            bus.req1_ready = accept &&  grant_id;
            if (accept)
               state_nxt = sel_legal ? EXEC : RESP;
         end
         EXEC: begin
            bus.alu_a  = lat_a;
            bus.alu_b  = lat_b;
            bus.alu_op = lat_op;
            state_nxt  = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Response fields are cleared at acceptance so an illegal op reports
   // zero result/flags; a legal op overwrites them at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant   <= 1'b1;
         lat_a        <= '0;
         lat_b        <= '0;
         lat_op       <= '0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else if (accept) begin
         last_grant   <= grant_id;
         lat_a        <= sel_a;
         lat_b        <= sel_b;
         lat_op       <= sel_op;
         rsp_id_q     <= grant_id;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= ~sel_legal;
      end else if (state == EXEC) begin
         rsp_result_q <= bus.alu_result;
         rsp_flags_q  <= bus.alu_flags;
      end
   end

   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0v, r1v, rr;
   logic [31:0] r0a, r0b, r1a, r1b;
   logic [3:0]  r0op, r1op;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter_if bus_f();
   alu_arbiter_if bus_p();

   // Reference ALU: flags are {carry, overflow, zero, set}.
   function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v, st;
      s = '0; r = '0; c = 1'b0; v = 1'b0; st = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010, 4'b0011: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'b0100, 4'b0111: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'b0101: begin st = ($signed(a) < $signed(b)); r = {31'b0, st}; end
         4'b0110: begin st = (a < b); r = {31'b0, st}; end
         4'b1001: r = a << b;
         4'b1010: r = a >> b;
         default: r = '0;
      endcase
      return {c, v, (r == 32'd0), st, r};
   endfunction

   assign bus_f.req0_valid = r0v;  assign bus_p.req0_valid = r0v;
   assign bus_f.req0_a     = r0a;  assign bus_p.req0_a     = r0a;
   assign bus_f.req0_b     = r0b;  assign bus_p.req0_b     = r0b;
   assign bus_f.req0_op    = r0op; assign bus_p.req0_op    = r0op;
   assign bus_f.req1_valid = r1v;  assign bus_p.req1_valid = r1v;
   assign bus_f.req1_a     = r1a;  assign bus_p.req1_a     = r1a;
   assign bus_f.req1_b     = r1b;  assign bus_p.req1_b     = r1b;
   assign bus_f.req1_op    = r1op; assign bus_p.req1_op    = r1op;
   assign bus_f.rsp_ready  = rr;   assign bus_p.rsp_ready  = rr;
   assign {bus_f.alu_flags, bus_f.alu_result} = alu_model(bus_f.alu_a, bus_f.alu_b, bus_f.alu_op);
   assign {bus_p.alu_flags, bus_p.alu_result} = alu_model(bus_p.alu_a, bus_p.alu_b, bus_p.alu_op);

   alu_arbiter #(.FAIR(1)) u_dut    (.clk(clk), .rst_n(rst_n), .bus(bus_f));
   alu_arbiter #(.FAIR(0)) u_dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_p));

   task automatic do_reset();
      @(negedge clk);
      r0v = 1'b0; r1v = 1'b0; rr = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0; rr = 1'b0;
      r0a = '0; r0b = '0; r0op = '0; r1a = '0; r1b = '0; r1op = '0;
      @(negedge clk);
      n_checks++;
      if (bus_f.rsp_valid !== 1'b0 || bus_f.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: rsp_valid=%b busy=%b, required 0 0", bus_f.rsp_valid, bus_f.busy);
      end
      n_checks++;
      if ({bus_f.alu_a, bus_f.alu_b, bus_f.alu_op} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_alu: alu_a=%h alu_b=%h alu_op=%h, required 0", bus_f.alu_a, bus_f.alu_b, bus_f.alu_op);
      end
      n_checks++;
      if ({bus_f.rsp_id, bus_f.rsp_result, bus_f.rsp_flags, bus_f.rsp_err} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_rsp: id=%b result=%h flags=%b err=%b, required 0",
                  bus_f.rsp_id, bus_f.rsp_result, bus_f.rsp_flags, bus_f.rsp_err);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      r0v = 1'b1; r0op = 4'b0011; r0a = 32'h0000003f; r0b = 32'h7fffffff;
      #1;
      n_checks++;
      if (bus_f.req0_ready !== 1'b1 || bus_f.req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_grant: ready0=%b ready1=%b, required 1 0", bus_f.req0_ready, bus_f.req1_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus_f.alu_op !== 4'b0011 || bus_f.alu_a !== 32'h3f || bus_f.alu_b !== 32'h7fffffff ||
          bus_f.rsp_valid !== 1'b0 || bus_f.busy !== 1'b1 || bus_f.req0_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_exec: op=%h a=%h b=%h rsp_valid=%b busy=%b ready0=%b, required 3 3f 7fffffff 0 1 0",
                  bus_f.alu_op, bus_f.alu_a, bus_f.alu_b, bus_f.rsp_valid, bus_f.busy, bus_f.req0_ready);
      end
      r0v = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus_f.rsp_valid !== 1'b1 || bus_f.rsp_id !== 1'b0 || bus_f.rsp_result !== 32'h8000003e ||
          bus_f.rsp_flags !== 4'b0100 || bus_f.rsp_err !== 1'b0 || bus_f.alu_op !== 4'd0) begin
         n_fail++;
         $display("FAIL single_rsp: valid=%b id=%b result=%h flags=%b err=%b alu_op=%h, required 1 0 8000003e 0100 0 0",
                  bus_f.rsp_valid, bus_f.rsp_id, bus_f.rsp_result, bus_f.rsp_flags, bus_f.rsp_err, bus_f.alu_op);
      end
      rr = 1'b1;
      @(negedge clk);
      rr = 1'b0;
      n_checks++;
      if (bus_f.rsp_valid !== 1'b0 || bus_f.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: rsp_valid=%b busy=%b, required 0 0", bus_f.rsp_valid, bus_f.busy);
      end
   endtask

   task automatic test_illegal();
      r0v = 1'b1; r0op = 4'b1100; r0a = 32'h12345678; r0b = 32'h9abcdef0;
      #1;
      n_checks++;
      if (bus_f.req0_ready !== 1'b1 || bus_f.alu_op !== 4'd0) begin
         n_fail++;
         $display("FAIL illegal_grant: ready0=%b alu_op=%h, required 1 0", bus_f.req0_ready, bus_f.alu_op);
      end
      @(negedge clk);
      r0v = 1'b0;
      n_checks++;
      if (bus_f.rsp_valid !== 1'b1 || bus_f.rsp_err !== 1'b1 || bus_f.rsp_result !== 32'd0 ||
          bus_f.rsp_flags !== 4'd0 || bus_f.alu_op !== 4'd0 || bus_f.alu_a !== 32'd0) begin
         n_fail++;
         $display("FAIL illegal_rsp: valid=%b err=%b result=%h flags=%b alu_op=%h alu_a=%h, required 1 1 0 0 0 0",
                  bus_f.rsp_valid, bus_f.rsp_err, bus_f.rsp_result, bus_f.rsp_flags, bus_f.alu_op, bus_f.alu_a);
      end
      rr = 1'b1;
      @(negedge clk);
      rr = 1'b0;
      n_checks++;
      if (bus_f.rsp_valid !== 1'b0 || bus_f.alu_op !== 4'd0) begin
         n_fail++;
         $display("FAIL illegal_done: rsp_valid=%b alu_op=%h, required 0 0", bus_f.rsp_valid, bus_f.alu_op);
      end
   endtask

   task automatic test_tie();
      logic exp_f [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int nf = 0;
      int np = 0;
      do_reset();
      r0v = 1'b1; r0op = 4'b0000; r0a = 32'h0000f0f0; r0b = 32'h0000ff00;
      r1v = 1'b1; r1op = 4'b0001; r1a = 32'h0000000f; r1b = 32'h000000f0;
      rr = 1'b1;
      for (int i = 0; i < 40 && (nf < 4 || np < 4); i++) begin
         @(negedge clk);
         if (bus_f.rsp_valid && nf < 4) begin
            n_checks++;
            if (bus_f.rsp_id !== exp_f[nf] ||
                bus_f.rsp_result !== (exp_f[nf] ? 32'h000000ff : 32'h0000f000)) begin
               n_fail++;
               $display("FAIL tie_fair[%0d]: id=%b result=%h, required id %b", nf, bus_f.rsp_id,
                        bus_f.rsp_result, exp_f[nf]);
            end
            nf++;
         end
         if (bus_p.rsp_valid && np < 4) begin
            n_checks++;
            if (bus_p.rsp_id !== 1'b0 || bus_p.rsp_result !== 32'h0000f000) begin
               n_fail++;
               $display("FAIL tie_prio[%0d]: id=%b result=%h, required 0 0000f000", np, bus_p.rsp_id,
                        bus_p.rsp_result);
            end
            np++;
         end
      end
      n_checks++;
      if (nf != 4 || np != 4) begin
         n_fail++;
         $display("FAIL tie_count: fair=%0d prio=%0d responses, required 4 4", nf, np);
      end
      @(negedge clk);
      r0v = 1'b0; r1v = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rr = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      r1v = 1'b1; r1op = 4'b0110; r1a = 32'h80000000; r1b = 32'h80000001; rr = 1'b0;
      @(negedge clk);
      r0v = 1'b1; r0op = 4'b0011; r1op = 4'b0000;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (bus_f.rsp_valid !== 1'b1 || bus_f.rsp_id !== 1'b1 || bus_f.rsp_result !== 32'd1 ||
             bus_f.rsp_flags !== 4'b0001 || bus_f.rsp_err !== 1'b0 ||
             bus_f.req0_ready !== 1'b0 || bus_f.req1_ready !== 1'b0 || bus_f.alu_op !== 4'd0) begin
            n_fail++;
            $display("FAIL backpressure[%0d]: valid=%b id=%b result=%h flags=%b err=%b ready=%b%b alu_op=%h, required 1 1 1 0001 0 00 0",
                     k, bus_f.rsp_valid, bus_f.rsp_id, bus_f.rsp_result, bus_f.rsp_flags, bus_f.rsp_err,
                     bus_f.req0_ready, bus_f.req1_ready, bus_f.alu_op);
         end
         @(negedge clk);
      end
      r0v = 1'b0; r1v = 1'b0; rr = 1'b1;
      @(negedge clk);
      rr = 1'b0;
      n_checks++;
      if (bus_f.rsp_valid !== 1'b0 || bus_f.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_done: rsp_valid=%b busy=%b, required 0 0", bus_f.rsp_valid, bus_f.busy);
      end
   endtask

   task automatic test_reset_mid_exec();
      logic seen = 1'b0;
      r1v = 1'b1; r1op = 4'b0100; r1a = 32'h1fffffff; r1b = 32'd6;
      @(negedge clk);
      r1v = 1'b0;
      n_checks++;
      if (bus_f.alu_op !== 4'b0100 || bus_f.alu_a !== 32'h1fffffff || bus_f.alu_b !== 32'd6) begin
         n_fail++;
         $display("FAIL midexec_exec: op=%h a=%h b=%h, required 4 1fffffff 6", bus_f.alu_op, bus_f.alu_a, bus_f.alu_b);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus_f.busy !== 1'b0 || bus_f.rsp_valid !== 1'b0 ||
          {bus_f.alu_a, bus_f.alu_b, bus_f.alu_op} !== 68'd0 ||
          {bus_f.rsp_id, bus_f.rsp_result, bus_f.rsp_flags, bus_f.rsp_err} !== 38'd0) begin
         n_fail++;
         $display("FAIL midexec_reset: busy=%b valid=%b alu_op=%h alu_a=%h id=%b result=%h flags=%b err=%b, required all 0",
                  bus_f.busy, bus_f.rsp_valid, bus_f.alu_op, bus_f.alu_a, bus_f.rsp_id,
                  bus_f.rsp_result, bus_f.rsp_flags, bus_f.rsp_err);
      end
      @(negedge clk);
      rst_n = 1'b1; rr = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_f.rsp_valid || bus_f.busy) seen = 1'b1;
      end
      rr = 1'b0;
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midexec_norsp: activity after reset=%b, required 0", seen);
      end
   endtask

   task automatic test_zero();
      r0v = 1'b1; r0op = 4'b1001; r0a = 32'h00001000; r0b = 32'h00001000;
      @(negedge clk);
      r0v = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus_f.rsp_valid !== 1'b1 || bus_f.rsp_id !== 1'b0 || bus_f.rsp_result !== 32'd0 ||
          bus_f.rsp_flags !== 4'b0010 || bus_f.rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_flag: valid=%b id=%b result=%h flags=%b err=%b, required 1 0 0 0010 0",
                  bus_f.rsp_valid, bus_f.rsp_id, bus_f.rsp_result, bus_f.rsp_flags, bus_f.rsp_err);
      end
      rr = 1'b1;
      @(negedge clk);
      rr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_illegal();
      test_tie();
      test_backpressure();
      test_reset_mid_exec();
      test_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
